// File: rtl/sev_segm_pkg.sv
// -----------------------------------------------------------------------------
// sev_segm_pkg
//   Shared definitions for the DE2-115 seven-segment path. It is the single
//   source of truth for the active-low HEX digit patterns, so the encoder
//   and this readback decoder can never disagree.
//
//   Contents:
//     SEG_0 .. SEG_F, SEG_BLANK : active-low patterns, bit0=a ... bit6=g
//     filt_state_e              : stability filter states {SETTLING, STABLE}
//     seg_decode_t              : decode result {binary, blank, invalid}
//     seg_decode()              : pattern -> seg_decode_t
// -----------------------------------------------------------------------------
package sev_segm_pkg;

    // Active-low: a 0 bit lights the segment. Written as bit6 (g) .. bit0 (a).
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic {
        SETTLING = 1'b0,
        STABLE   = 1'b1
    } filt_state_e;

    typedef struct packed {
        logic [3:0] binary;
        logic       blank;
        logic       invalid;
    } seg_decode_t;

    // Blank and illegal patterns both decode to binary=0.
    function automatic seg_decode_t seg_decode(input logic [6:0] seg);
        seg_decode_t r;
        r = '{binary: 4'h0, blank: 1'b0, invalid: 1'b0};
        case (seg)
            SEG_0:     r.binary = 4'h0;
            SEG_1:     r.binary = 4'h1;
            SEG_2:     r.binary = 4'h2;
            SEG_3:     r.binary = 4'h3;
            SEG_4:     r.binary = 4'h4;
            SEG_5:     r.binary = 4'h5;
            SEG_6:     r.binary = 4'h6;
            SEG_7:     r.binary = 4'h7;
            SEG_8:     r.binary = 4'h8;
            SEG_9:     r.binary = 4'h9;
            SEG_A:     r.binary = 4'hA;
            SEG_B:     r.binary = 4'hB;
            SEG_C:     r.binary = 4'hC;
            SEG_D:     r.binary = 4'hD;
            SEG_E:     r.binary = 4'hE;
            SEG_F:     r.binary = 4'hF;
            SEG_BLANK: r.blank  = 1'b1;
            default:   r.invalid = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sev_segm_stability_filter.sv
// -----------------------------------------------------------------------------
// sev_segm_stability_filter
//   Samples the segment bus every cycle and reports, for exactly one cycle,
//   when a pattern has been held for STABLE_CYCLES consecutive samples.
//
//   Parameters:
//     STABLE_CYCLES : consecutive samples needed before a pattern counts
//                     as stable (1..255)
//   Ports:
//     clk          in   system clock, rising edge
//     reset        in   synchronous, active-high
//     segments     in   raw active-low segment bus
//     stable_pulse out  high in the single cycle the filter becomes stable
//     pattern      out  sampled pattern (valid while stable_pulse is high)
// -----------------------------------------------------------------------------
module sev_segm_stability_filter
    import sev_segm_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] segments,
    output logic       stable_pulse,
    output logic [6:0] pattern
);

    localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);

    logic [6:0]  s_q;
    logic [7:0]  cnt_q, cnt_d;
    filt_state_e state_q, state_d;
    logic        changed;

    assign changed = (segments != s_q);

    // The state register trails the counter by one cycle: the cycle where
    // cnt has just reached CNT_MAX while still SETTLING is the entry cycle,
    // and that is where the pulse is raised. It depends on registers only.
    assign stable_pulse = (state_q == SETTLING) && (cnt_q == CNT_MAX);
    assign pattern      = s_q;

    // NOTE: every signal written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        cnt_d   = cnt_q;
        state_d = state_q;

        if (changed) begin
            cnt_d = 8'd0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 8'd1;
        end

        case (state_q)
            SETTLING: if (!changed && cnt_q == CNT_MAX) state_d = STABLE;
            STABLE:   if (changed)                      state_d = SETTLING;
            default:                                    state_d = SETTLING;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            s_q     <= SEG_BLANK;
            cnt_q   <= 8'd0;
            state_q <= SETTLING;
        end else begin
            s_q     <= segments;
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

endmodule

// File: rtl/sev_segm_to_binary.sv
// -----------------------------------------------------------------------------
// sev_segm_to_binary
//   Seven-segment readback decoder. Waits for the active-low segment pattern
//   driven to a HEX digit to hold stable, decodes it back to a nibble and
//   offers it through a one-entry valid/ready buffer. A held or repeated
//   pattern is reported once.
//
//   Build option:
//     SEV_SEGM_DEC_INVALID_EN  defined: illegal patterns produce events with
//                              invalid=1, binary=0. Undefined: illegal
//                              patterns are discarded and invalid is 0.
//
//   Parameters:
//     STABLE_CYCLES : samples a pattern must hold before decode (1..255)
//   Ports:
//     clk        in   system clock, rising edge
//     reset      in   synchronous, active-high
//     segments   in   active-low pattern, bit0=a ... bit6=g
//     out_valid  out  buffer holds an event
//     out_ready  in   consumer takes the event on an edge with out_valid=1
//     binary     out  decoded nibble (0 for blank/invalid)
//     blank      out  event pattern was all segments off
//     invalid    out  event pattern is not a legal code
//     overrun    out  sticky: an event was dropped on a full buffer
// -----------------------------------------------------------------------------
module sev_segm_to_binary
    import sev_segm_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] segments,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] binary,
    output logic       blank,
    output logic       invalid,
    output logic       overrun
);

    logic        stable_pulse;
    logic [6:0]  pattern;
    seg_decode_t dec;
    logic        accept;
    logic        fire;
    logic        xfer;
    logic        emitted_q;
    logic [6:0]  last_q;

    sev_segm_stability_filter #(
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_filter (
        .clk          (clk),
        .reset        (reset),
        .segments     (segments),
        .stable_pulse (stable_pulse),
        .pattern      (pattern)
    );

    assign dec = seg_decode(pattern);

`ifdef SEV_SEGM_DEC_INVALID_EN
    assign accept = 1'b1;
`else
    assign accept = !dec.invalid;
`endif

    // Suppress repeats: only a pattern different from the last emitted one
    // (or the first one after reset) fires.
    assign fire = stable_pulse && accept && (!emitted_q || pattern != last_q);
    assign xfer = out_valid && out_ready;

    // The last-emitted record updates on every fired event, including one
    // that the buffer then drops.
    always_ff @(posedge clk) begin
        if (reset) begin
            emitted_q <= 1'b0;
            last_q    <= SEG_BLANK;
        end else if (fire) begin
            emitted_q <= 1'b1;
            last_q    <= pattern;
        end
    end

    // A full buffer that is draining on this edge can take a new event.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            binary    <= 4'h0;
            blank     <= 1'b0;
            overrun   <= 1'b0;
        end else if (fire && (!out_valid || out_ready)) begin
            out_valid <= 1'b1;
            binary    <= dec.binary;
            blank     <= dec.blank;
        end else if (fire) begin
            overrun   <= 1'b1;
        end else if (xfer) begin
            out_valid <= 1'b0;
        end
    end

`ifdef SEV_SEGM_DEC_INVALID_EN
    logic invalid_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            invalid_q <= 1'b0;
        end else if (fire && (!out_valid || out_ready)) begin
            invalid_q <= dec.invalid;
        end
    end

    assign invalid = invalid_q;
`else
    assign invalid = 1'b0;
`endif

endmodule

// File: tb/tb_sev_segm_to_binary.sv
// -----------------------------------------------------------------------------
// tb_sev_segm_to_binary
//   Directed bench for sev_segm_to_binary with STABLE_CYCLES=4. Inputs are
//   driven and outputs sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_sev_segm_to_binary;

    localparam int SC = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] segments;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] binary;
    logic       blank;
    logic       invalid;
    logic       overrun;

    int         compared   = 0;
    int         mismatched = 0;
    int         xfers      = 0;
    logic [3:0] last_bin   = 4'h0;
    int         x0;

    always #5 clk = ~clk;

    sev_segm_to_binary #(
        .STABLE_CYCLES (SC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .segments  (segments),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .binary    (binary),
        .blank     (blank),
        .invalid   (invalid),
        .overrun   (overrun)
    );

    // Count handshakes and remember what was transferred.
    always @(posedge clk) begin
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            xfers    = xfers + 1;
            last_bin = binary;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; segments = 7'b1111111; out_ready = 1'b0;
        cycles(2);
        compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL rst_valid: got %b want 0", out_valid); end
        compared++; if (binary !== 4'h0) begin mismatched++; $display("FAIL rst_binary: got %h want 0", binary); end
        compared++; if (blank !== 1'b0) begin mismatched++; $display("FAIL rst_blank: got %b want 0", blank); end
        compared++; if (invalid !== 1'b0) begin mismatched++; $display("FAIL rst_invalid: got %b want 0", invalid); end
        compared++; if (overrun !== 1'b0) begin mismatched++; $display("FAIL rst_overrun: got %b want 0", overrun); end
    endtask

    // 0100100 (2) held 10 cycles, out_ready=1: one event, visible one cycle.
    task automatic test_basic;
        x0 = xfers;
        reset = 1'b0; segments = 7'b0100100; out_ready = 1'b1;
        cycles(4);
        compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL basic_early: got %b want 0", out_valid); end
        cycles(1);
        compared++; if (out_valid !== 1'b1) begin mismatched++; $display("FAIL basic_valid: got %b want 1", out_valid); end
        compared++; if (binary !== 4'h2) begin mismatched++; $display("FAIL basic_binary: got %h want 2", binary); end
        compared++; if (blank !== 1'b0) begin mismatched++; $display("FAIL basic_blank: got %b want 0", blank); end
        compared++; if (invalid !== 1'b0) begin mismatched++; $display("FAIL basic_invalid: got %b want 0", invalid); end
        cycles(1);
        compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL basic_onecycle: got %b want 0", out_valid); end
        cycles(4);
        compared++; if (xfers - x0 !== 1) begin mismatched++; $display("FAIL basic_count: got %0d want 1", xfers - x0); end
        compared++; if (last_bin !== 4'h2) begin mismatched++; $display("FAIL basic_xfer_bin: got %h want 2", last_bin); end
    endtask

    // 8 held for only 2 samples is a glitch; 9 held 6 samples emits.
    task automatic test_glitch;
        x0 = xfers;
        segments = 7'b0000000;
        cycles(2);
        segments = 7'b0010000;
        cycles(4);
        compared++; if (xfers - x0 !== 0) begin mismatched++; $display("FAIL glitch_none: got %0d want 0", xfers - x0); end
        compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL glitch_early: got %b want 0", out_valid); end
        cycles(1);
        compared++; if (out_valid !== 1'b1) begin mismatched++; $display("FAIL glitch_valid: got %b want 1", out_valid); end
        compared++; if (binary !== 4'h9) begin mismatched++; $display("FAIL glitch_binary: got %h want 9", binary); end
        cycles(1);
        compared++; if (xfers - x0 !== 1) begin mismatched++; $display("FAIL glitch_count: got %0d want 1", xfers - x0); end
        compared++; if (last_bin !== 4'h9) begin mismatched++; $display("FAIL glitch_xfer_bin: got %h want 9", last_bin); end
    endtask

    task automatic test_blank_invalid;
        segments = 7'b1111111;
        cycles(5);
        compared++; if (out_valid !== 1'b1) begin mismatched++; $display("FAIL blank_valid: got %b want 1", out_valid); end
        compared++; if (blank !== 1'b1) begin mismatched++; $display("FAIL blank_flag: got %b want 1", blank); end
        compared++; if (binary !== 4'h0) begin mismatched++; $display("FAIL blank_binary: got %h want 0", binary); end
        compared++; if (invalid !== 1'b0) begin mismatched++; $display("FAIL blank_invalid: got %b want 0", invalid); end
        cycles(1);
        x0 = xfers;
        segments = 7'b0101010;
        cycles(5);
`ifdef SEV_SEGM_DEC_INVALID_EN
        compared++; if (out_valid !== 1'b1) begin mismatched++; $display("FAIL inv_valid: got %b want 1", out_valid); end
        compared++; if (invalid !== 1'b1) begin mismatched++; $display("FAIL inv_flag: got %b want 1", invalid); end
        compared++; if (binary !== 4'h0) begin mismatched++; $display("FAIL inv_binary: got %h want 0", binary); end
        compared++; if (blank !== 1'b0) begin mismatched++; $display("FAIL inv_blank: got %b want 0", blank); end
        cycles(1);
`else
        compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL inv_dropped: got %b want 0", out_valid); end
        compared++; if (invalid !== 1'b0) begin mismatched++; $display("FAIL inv_tied: got %b want 0", invalid); end
        cycles(1);
        compared++; if (xfers - x0 !== 0) begin mismatched++; $display("FAIL inv_count: got %0d want 0", xfers - x0); end
`endif
    endtask

    // New event lands on the same edge as a transfer: buffer stays full.
    task automatic test_back_to_back;
        out_ready = 1'b0; segments = 7'b1000000;
        cycles(6);
        compared++; if (out_valid !== 1'b1) begin mismatched++; $display("FAIL b2b_first_valid: got %b want 1", out_valid); end
        x0 = xfers;
        segments = 7'b0001000;
        cycles(4);
        out_ready = 1'b1;
        cycles(1);
        compared++; if (out_valid !== 1'b1) begin mismatched++; $display("FAIL b2b_valid: got %b want 1", out_valid); end
        compared++; if (binary !== 4'hA) begin mismatched++; $display("FAIL b2b_binary: got %h want a", binary); end
        compared++; if (overrun !== 1'b0) begin mismatched++; $display("FAIL b2b_overrun: got %b want 0", overrun); end
        compared++; if (xfers - x0 !== 1) begin mismatched++; $display("FAIL b2b_count1: got %0d want 1", xfers - x0); end
        cycles(1);
        compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL b2b_drain: got %b want 0", out_valid); end
        compared++; if (xfers - x0 !== 2) begin mismatched++; $display("FAIL b2b_count2: got %0d want 2", xfers - x0); end
        compared++; if (last_bin !== 4'hA) begin mismatched++; $display("FAIL b2b_xfer_bin: got %h want a", last_bin); end
    endtask

    task automatic test_overrun;
        out_ready = 1'b0; segments = 7'b1111001;
        cycles(6);
        compared++; if (binary !== 4'h1) begin mismatched++; $display("FAIL ovr_first_bin: got %h want 1", binary); end
        compared++; if (overrun !== 1'b0) begin mismatched++; $display("FAIL ovr_before: got %b want 0", overrun); end
        segments = 7'b0001110;
        cycles(6);
        compared++; if (out_valid !== 1'b1) begin mismatched++; $display("FAIL ovr_valid: got %b want 1", out_valid); end
        compared++; if (binary !== 4'h1) begin mismatched++; $display("FAIL ovr_kept: got %h want 1", binary); end
        compared++; if (overrun !== 1'b1) begin mismatched++; $display("FAIL ovr_flag: got %b want 1", overrun); end
        x0 = xfers;
        out_ready = 1'b1;
        cycles(1);
        compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL ovr_drain: got %b want 0", out_valid); end
        compared++; if (xfers - x0 !== 1) begin mismatched++; $display("FAIL ovr_count: got %0d want 1", xfers - x0); end
        compared++; if (last_bin !== 4'h1) begin mismatched++; $display("FAIL ovr_xfer_bin: got %h want 1", last_bin); end
        cycles(4);
        compared++; if (overrun !== 1'b1) begin mismatched++; $display("FAIL ovr_sticky: got %b want 1", overrun); end
        compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL ovr_no_reemit: got %b want 0", out_valid); end
    endtask

    task automatic test_reset_mid;
        out_ready = 1'b0; segments = 7'b1000110;
        cycles(6);
        compared++; if (binary !== 4'hC) begin mismatched++; $display("FAIL rmid_binary: got %h want c", binary); end
        compared++; if (out_valid !== 1'b1) begin mismatched++; $display("FAIL rmid_valid: got %b want 1", out_valid); end
        reset = 1'b1;
        cycles(1);
        compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL rmid_clr_valid: got %b want 0", out_valid); end
        compared++; if (binary !== 4'h0) begin mismatched++; $display("FAIL rmid_clr_binary: got %h want 0", binary); end
        compared++; if (blank !== 1'b0) begin mismatched++; $display("FAIL rmid_clr_blank: got %b want 0", blank); end
        compared++; if (invalid !== 1'b0) begin mismatched++; $display("FAIL rmid_clr_invalid: got %b want 0", invalid); end
        compared++; if (overrun !== 1'b0) begin mismatched++; $display("FAIL rmid_clr_overrun: got %b want 0", overrun); end
        reset = 1'b0;
        cycles(4);
        compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL rmid_early: got %b want 0", out_valid); end
        cycles(1);
        compared++; if (out_valid !== 1'b1) begin mismatched++; $display("FAIL rmid_reemit: got %b want 1", out_valid); end
        compared++; if (binary !== 4'hC) begin mismatched++; $display("FAIL rmid_reemit_bin: got %h want c", binary); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_blank_invalid();
        test_back_to_back();
        test_overrun();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
